// File: rtl/pong_pkg.sv
// ============================================================================
// pong_pkg : shared state encodings, overlay/serve/hit codes and BCD helpers
// Revision : 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [1:0] TEXT_NONE    = 2'b00;
  localparam logic [1:0] TEXT_START   = 2'b01;
  localparam logic [1:0] TEXT_READY   = 2'b10;
  localparam logic [1:0] TEXT_OVER    = 2'b11;

  localparam logic [1:0] HIT_LEFT     = 2'b01;
  localparam logic [1:0] HIT_RIGHT    = 2'b10;

  localparam logic [1:0] SERVE_RANDOM = 2'b00;
  localparam logic [1:0] SERVE_P1     = 2'b01;
  localparam logic [1:0] SERVE_P2     = 2'b10;

  localparam logic [1:0] WIN_NONE     = 2'b00;
  localparam logic [1:0] WIN_P1       = 2'b01;
  localparam logic [1:0] WIN_P2       = 2'b10;

  // Two-digit BCD increment, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] >= 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pong_game_ctrl_if.sv
// ============================================================================
// pong_game_ctrl_if : graphics/button/score bundle of the Pong game controller
// Revision : 1.0   (freeze present only when PONG_PAUSE_EN is defined)
// ============================================================================
`default_nettype none

interface pong_game_ctrl_if;
  logic       refresh_tick;
  logic       start_btn;
  logic       miss;
  logic [1:0] hit;
  logic       gra_still;
  logic [1:0] serve_dir;
  logic [7:0] p1_score;
  logic [7:0] p2_score;
  logic [1:0] winner;
  logic [1:0] text_sel;
`ifdef PONG_PAUSE_EN
  logic       freeze;

  modport master (
    output refresh_tick, start_btn, miss, hit,
    input  gra_still, serve_dir, p1_score, p2_score, winner, text_sel, freeze
  );
  modport slave (
    input  refresh_tick, start_btn, miss, hit,
    output gra_still, serve_dir, p1_score, p2_score, winner, text_sel, freeze
  );
`else
  modport master (
    output refresh_tick, start_btn, miss, hit,
    input  gra_still, serve_dir, p1_score, p2_score, winner, text_sel
  );
  modport slave (
    input  refresh_tick, start_btn, miss, hit,
    output gra_still, serve_dir, p1_score, p2_score, winner, text_sel
  );
`endif
endinterface

`default_nettype wire

// File: rtl/pong_bcd2_counter.sv
// ============================================================================
// pong_bcd2_counter : two-digit BCD score counter, sync clear, saturates at 99
// Revision : 1.0
// ============================================================================
`default_nettype none

module pong_bcd2_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] value_o
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i)
      value_d = 8'h00;
    else if (inc_i)
      value_d = bcd_inc(value_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      value_q <= 8'h00;
    else
      value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
// ============================================================================
// pong_game_ctrl : Pong match sequencer (new game / play / new ball / over)
// Revision : 1.0   Optional in-play pause: define PONG_PAUSE_EN
// ============================================================================
`default_nettype none

module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 5,
  parameter int DELAY_TICKS = 120,
  parameter int TIMER_W     = 8
) (
  input logic             clk,
  input logic             reset,
  pong_game_ctrl_if.slave bus
);

  localparam logic [7:0]         WIN_BCD    = to_bcd(WIN_SCORE);
  localparam logic [TIMER_W-1:0] DELAY_LOAD = TIMER_W'(DELAY_TICKS);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         serve_q, serve_d;
  logic [1:0]         winner_q, winner_d;
  logic [1:0]         text_q, text_d;
  logic               gra_still_q, gra_still_d;
  logic               start_q;
  logic               start_pulse;
  logic               miss_live;
  logic               p1_inc, p2_inc, score_clr;
  logic [7:0]         p1_score, p2_score;

  assign start_pulse = bus.start_btn & ~start_q;

`ifdef PONG_PAUSE_EN
  logic pause_q, pause_d;
  logic freeze_q, freeze_d;
  assign miss_live = bus.miss & ~pause_q;
`else
  assign miss_live = bus.miss;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    serve_d   = serve_q;
    winner_d  = winner_q;
    p1_inc    = 1'b0;
    p2_inc    = 1'b0;
    score_clr = 1'b0;
`ifdef PONG_PAUSE_EN
    pause_d   = pause_q;
`endif
    case (state_q)
      NEWGAME: begin
        if (start_pulse) begin
          state_d   = PLAY;
          score_clr = 1'b1;
          winner_d  = WIN_NONE;
        end
      end
      PLAY: begin
`ifdef PONG_PAUSE_EN
        if (start_pulse)
          pause_d = ~pause_q;
`endif
        // A miss always wins over a coincident refresh tick: the timer reloads.
        if (miss_live) begin
          timer_d = DELAY_LOAD;
          state_d = NEWBALL;
          if (bus.hit == HIT_RIGHT) begin
            p1_inc  = 1'b1;
            serve_d = SERVE_P2;
            if (bcd_inc(p1_score) == WIN_BCD) begin
              state_d  = OVER;
              winner_d = WIN_P1;
            end
          end else if (bus.hit == HIT_LEFT) begin
            p2_inc  = 1'b1;
            serve_d = SERVE_P1;
            if (bcd_inc(p2_score) == WIN_BCD) begin
              state_d  = OVER;
              winner_d = WIN_P2;
            end
          end else begin
            serve_d = SERVE_RANDOM;
          end
        end
      end
      NEWBALL: begin
        if (timer_q == '0)
          state_d = PLAY;
        else if (bus.refresh_tick)
          timer_d = timer_q - 1'b1;
      end
      OVER: begin
        if (timer_q == '0)
          state_d = NEWGAME;
        else if (bus.refresh_tick)
          timer_d = timer_q - 1'b1;
      end
      default: state_d = NEWGAME;
    endcase

    gra_still_d = (state_d != PLAY);
    case (state_d)
      NEWGAME: text_d = TEXT_START;
      PLAY:    text_d = TEXT_NONE;
      NEWBALL: text_d = TEXT_READY;
      default: text_d = TEXT_OVER;
    endcase

`ifdef PONG_PAUSE_EN
    if (state_d != PLAY)
      pause_d = 1'b0;
    freeze_d = (state_d == PLAY) && pause_d;
    if (freeze_d)
      text_d = TEXT_READY;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= NEWGAME;
      timer_q     <= '0;
      serve_q     <= SERVE_RANDOM;
      winner_q    <= WIN_NONE;
      text_q      <= TEXT_START;
      gra_still_q <= 1'b1;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      serve_q     <= serve_d;
      winner_q    <= winner_d;
      text_q      <= text_d;
      gra_still_q <= gra_still_d;
      start_q     <= bus.start_btn;
    end
  end

`ifdef PONG_PAUSE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pause_q  <= 1'b0;
      freeze_q <= 1'b0;
    end else begin
      pause_q  <= pause_d;
      freeze_q <= freeze_d;
    end
  end
  assign bus.freeze = freeze_q;
`endif

  pong_bcd2_counter u_p1_score (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (score_clr),
    .inc_i   (p1_inc),
    .value_o (p1_score)
  );

  pong_bcd2_counter u_p2_score (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (score_clr),
    .inc_i   (p2_inc),
    .value_o (p2_score)
  );

  assign bus.gra_still = gra_still_q;
  assign bus.serve_dir = serve_q;
  assign bus.p1_score  = p1_score;
  assign bus.p2_score  = p2_score;
  assign bus.winner    = winner_q;
  assign bus.text_sel  = text_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// ============================================================================
// tb_pong_game_ctrl : directed self-checking bench for pong_game_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pong_game_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pong_game_ctrl_if pif ();
  pong_game_ctrl_if qif ();

  pong_game_ctrl #(.WIN_SCORE(5), .DELAY_TICKS(120), .TIMER_W(8)) dut (
    .clk(clk), .reset(rst_n), .bus(pif)
  );

  pong_game_ctrl #(.WIN_SCORE(99), .DELAY_TICKS(1), .TIMER_W(8)) dut99 (
    .clk(clk), .reset(rst_n), .bus(qif)
  );

  logic       c_clr = 1'b0;
  logic       c_inc = 1'b0;
  logic [7:0] c_val;

  pong_bcd2_counter cnt (
    .clk(clk), .reset(rst_n), .clr_i(c_clr), .inc_i(c_inc), .value_o(c_val)
  );

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pif.refresh_tick = 1'b1;
      cyc(1);
      pif.refresh_tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic start_press();
    pif.start_btn = 1'b1;
    cyc(1);
    pif.start_btn = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    checks++; if (pif.gra_still !== 1'b1) begin errors++; $display("FAIL reset_gra_still got=%b exp=1", pif.gra_still); end
    checks++; if (pif.text_sel !== 2'b01) begin errors++; $display("FAIL reset_text got=%b exp=01", pif.text_sel); end
    checks++; if (pif.serve_dir !== 2'b00) begin errors++; $display("FAIL reset_serve got=%b exp=00", pif.serve_dir); end
    checks++; if (pif.p1_score !== 8'h00) begin errors++; $display("FAIL reset_p1 got=%h exp=00", pif.p1_score); end
    checks++; if (pif.p2_score !== 8'h00) begin errors++; $display("FAIL reset_p2 got=%h exp=00", pif.p2_score); end
    checks++; if (pif.winner !== 2'b00) begin errors++; $display("FAIL reset_winner got=%b exp=00", pif.winner); end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_start();
    checks++; if (pif.text_sel !== 2'b01) begin errors++; $display("FAIL idle_text got=%b exp=01", pif.text_sel); end
    pif.start_btn = 1'b1;
    cyc(1);
    checks++; if (pif.gra_still !== 1'b0) begin errors++; $display("FAIL start_gra_still got=%b exp=0", pif.gra_still); end
    checks++; if (pif.text_sel !== 2'b00) begin errors++; $display("FAIL start_text got=%b exp=00", pif.text_sel); end
    checks++; if (pif.p1_score !== 8'h00) begin errors++; $display("FAIL start_p1 got=%h exp=00", pif.p1_score); end
    cyc(3);
    pif.start_btn = 1'b0;
    cyc(1);
  endtask

  task automatic test_p1_point();
    pif.hit = 2'b10;
    pif.miss = 1'b1;
    cyc(3);
    pif.miss = 1'b0;
    pif.hit = 2'b00;
    checks++; if (pif.p1_score !== 8'h01) begin errors++; $display("FAIL p1_point_score got=%h exp=01", pif.p1_score); end
    checks++; if (pif.serve_dir !== 2'b10) begin errors++; $display("FAIL p1_point_serve got=%b exp=10", pif.serve_dir); end
    checks++; if (pif.text_sel !== 2'b10) begin errors++; $display("FAIL p1_point_text got=%b exp=10", pif.text_sel); end
    ticks(119);
    checks++; if (pif.gra_still !== 1'b1) begin errors++; $display("FAIL newball_hold got=%b exp=1", pif.gra_still); end
    ticks(1);
    checks++; if (pif.gra_still !== 1'b0) begin errors++; $display("FAIL newball_release got=%b exp=0", pif.gra_still); end
    checks++; if (pif.text_sel !== 2'b00) begin errors++; $display("FAIL newball_release_text got=%b exp=00", pif.text_sel); end
  endtask

  task automatic test_p2_win();
    for (int i = 1; i <= 5; i++) begin
      pif.miss = 1'b1;
      pif.hit = 2'b01;
      cyc(1);
      pif.miss = 1'b0;
      pif.hit = 2'b00;
      cyc(1);
      if (i == 4) begin
        checks++; if (pif.winner !== 2'b00) begin errors++; $display("FAIL p2_four_winner got=%b exp=00", pif.winner); end
        checks++; if (pif.text_sel !== 2'b10) begin errors++; $display("FAIL p2_four_text got=%b exp=10", pif.text_sel); end
      end
      if (i < 5) ticks(120);
    end
    checks++; if (pif.winner !== 2'b10) begin errors++; $display("FAIL p2_win_winner got=%b exp=10", pif.winner); end
    checks++; if (pif.text_sel !== 2'b11) begin errors++; $display("FAIL p2_win_text got=%b exp=11", pif.text_sel); end
    checks++; if (pif.p2_score !== 8'h05) begin errors++; $display("FAIL p2_win_score got=%h exp=05", pif.p2_score); end
    checks++; if (pif.serve_dir !== 2'b01) begin errors++; $display("FAIL p2_win_serve got=%b exp=01", pif.serve_dir); end
    ticks(120);
    checks++; if (pif.text_sel !== 2'b01) begin errors++; $display("FAIL over_done_text got=%b exp=01", pif.text_sel); end
    checks++; if (pif.p2_score !== 8'h05) begin errors++; $display("FAIL over_hold_p2 got=%h exp=05", pif.p2_score); end
    checks++; if (pif.winner !== 2'b10) begin errors++; $display("FAIL over_hold_winner got=%b exp=10", pif.winner); end
    start_press();
    checks++; if (pif.p2_score !== 8'h00) begin errors++; $display("FAIL restart_p2 got=%h exp=00", pif.p2_score); end
    checks++; if (pif.winner !== 2'b00) begin errors++; $display("FAIL restart_winner got=%b exp=00", pif.winner); end
    checks++; if (pif.serve_dir !== 2'b01) begin errors++; $display("FAIL restart_serve_kept got=%b exp=01", pif.serve_dir); end
  endtask

  task automatic test_no_hit();
    pif.miss = 1'b1;
    pif.hit = 2'b11;
    cyc(1);
    pif.miss = 1'b0;
    pif.hit = 2'b00;
    checks++; if (pif.serve_dir !== 2'b00) begin errors++; $display("FAIL nohit_serve got=%b exp=00", pif.serve_dir); end
    checks++; if (pif.p1_score !== 8'h00) begin errors++; $display("FAIL nohit_p1 got=%h exp=00", pif.p1_score); end
    checks++; if (pif.p2_score !== 8'h00) begin errors++; $display("FAIL nohit_p2 got=%h exp=00", pif.p2_score); end
    checks++; if (pif.text_sel !== 2'b10) begin errors++; $display("FAIL nohit_text got=%b exp=10", pif.text_sel); end
    ticks(120);
  endtask

  task automatic test_miss_tick_and_reset();
    pif.miss = 1'b1;
    pif.hit = 2'b10;
    pif.refresh_tick = 1'b1;
    cyc(1);
    pif.miss = 1'b0;
    pif.hit = 2'b00;
    pif.refresh_tick = 1'b0;
    cyc(1);
    ticks(119);
    checks++; if (pif.gra_still !== 1'b1) begin errors++; $display("FAIL miss_tick_reload got=%b exp=1", pif.gra_still); end
    ticks(1);
    checks++; if (pif.gra_still !== 1'b0) begin errors++; $display("FAIL miss_tick_release got=%b exp=0", pif.gra_still); end
    pif.miss = 1'b1;
    pif.hit = 2'b10;
    cyc(1);
    pif.miss = 1'b0;
    pif.hit = 2'b00;
    ticks(10);
    checks++; if (pif.p1_score !== 8'h02) begin errors++; $display("FAIL pre_reset_p1 got=%h exp=02", pif.p1_score); end
    rst_n = 1'b0;
    #2;
    checks++; if (pif.gra_still !== 1'b1) begin errors++; $display("FAIL async_gra_still got=%b exp=1", pif.gra_still); end
    checks++; if (pif.text_sel !== 2'b01) begin errors++; $display("FAIL async_text got=%b exp=01", pif.text_sel); end
    checks++; if (pif.p1_score !== 8'h00) begin errors++; $display("FAIL async_p1 got=%h exp=00", pif.p1_score); end
    checks++; if (pif.serve_dir !== 2'b00) begin errors++; $display("FAIL async_serve got=%b exp=00", pif.serve_dir); end
    pif.miss = 1'b1;
    pif.hit = 2'b10;
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    pif.miss = 1'b0;
    pif.hit = 2'b00;
    checks++; if (pif.p1_score !== 8'h00) begin errors++; $display("FAIL residual_miss_p1 got=%h exp=00", pif.p1_score); end
    checks++; if (pif.text_sel !== 2'b01) begin errors++; $display("FAIL residual_miss_text got=%b exp=01", pif.text_sel); end
  endtask

  task automatic test_bcd_carry_win99();
    qif.start_btn = 1'b1;
    cyc(1);
    qif.start_btn = 1'b0;
    cyc(1);
    for (int i = 1; i <= 99; i++) begin
      qif.miss = 1'b1;
      qif.hit = 2'b10;
      cyc(1);
      qif.miss = 1'b0;
      qif.hit = 2'b00;
      if (i == 9) begin
        checks++; if (qif.p1_score !== 8'h09) begin errors++; $display("FAIL bcd_nine got=%h exp=09", qif.p1_score); end
      end
      if (i == 10) begin
        checks++; if (qif.p1_score !== 8'h10) begin errors++; $display("FAIL bcd_carry got=%h exp=10", qif.p1_score); end
      end
      if (i < 99) begin
        qif.refresh_tick = 1'b1;
        cyc(1);
        qif.refresh_tick = 1'b0;
        cyc(2);
      end
    end
    checks++; if (qif.p1_score !== 8'h99) begin errors++; $display("FAIL win99_score got=%h exp=99", qif.p1_score); end
    checks++; if (qif.winner !== 2'b01) begin errors++; $display("FAIL win99_winner got=%b exp=01", qif.winner); end
    checks++; if (qif.text_sel !== 2'b11) begin errors++; $display("FAIL win99_text got=%b exp=11", qif.text_sel); end
    checks++; if (qif.serve_dir !== 2'b10) begin errors++; $display("FAIL win99_serve got=%b exp=10", qif.serve_dir); end
  endtask

  task automatic test_saturate();
    c_clr = 1'b1;
    cyc(1);
    c_clr = 1'b0;
    checks++; if (c_val !== 8'h00) begin errors++; $display("FAIL cnt_clear got=%h exp=00", c_val); end
    c_inc = 1'b1;
    cyc(9);
    checks++; if (c_val !== 8'h09) begin errors++; $display("FAIL cnt_nine got=%h exp=09", c_val); end
    cyc(1);
    checks++; if (c_val !== 8'h10) begin errors++; $display("FAIL cnt_carry got=%h exp=10", c_val); end
    cyc(95);
    checks++; if (c_val !== 8'h99) begin errors++; $display("FAIL cnt_saturate got=%h exp=99", c_val); end
    c_inc = 1'b0;
    c_clr = 1'b1;
    cyc(1);
    c_clr = 1'b0;
    checks++; if (c_val !== 8'h00) begin errors++; $display("FAIL cnt_reclear got=%h exp=00", c_val); end
  endtask

`ifdef PONG_PAUSE_EN
  task automatic test_pause();
    start_press();
    pif.start_btn = 1'b1;
    cyc(1);
    checks++; if (pif.freeze !== 1'b1) begin errors++; $display("FAIL pause_freeze got=%b exp=1", pif.freeze); end
    checks++; if (pif.text_sel !== 2'b10) begin errors++; $display("FAIL pause_text got=%b exp=10", pif.text_sel); end
    checks++; if (pif.gra_still !== 1'b0) begin errors++; $display("FAIL pause_gra_still got=%b exp=0", pif.gra_still); end
    pif.start_btn = 1'b0;
    pif.miss = 1'b1;
    pif.hit = 2'b10;
    cyc(2);
    pif.miss = 1'b0;
    pif.hit = 2'b00;
    checks++; if (pif.p1_score !== 8'h00) begin errors++; $display("FAIL pause_miss_ignored got=%h exp=00", pif.p1_score); end
    start_press();
    checks++; if (pif.freeze !== 1'b0) begin errors++; $display("FAIL unpause_freeze got=%b exp=0", pif.freeze); end
    checks++; if (pif.text_sel !== 2'b00) begin errors++; $display("FAIL unpause_text got=%b exp=00", pif.text_sel); end
  endtask
`endif

  initial begin
    pif.refresh_tick = 1'b0;
    pif.start_btn    = 1'b0;
    pif.miss         = 1'b0;
    pif.hit          = 2'b00;
    qif.refresh_tick = 1'b0;
    qif.start_btn    = 1'b0;
    qif.miss         = 1'b0;
    qif.hit          = 2'b00;
    test_reset();
    test_start();
    test_p1_point();
    test_p2_win();
    test_no_hit();
    test_miss_tick_and_reset();
    test_bcd_carry_win99();
    test_saturate();
`ifdef PONG_PAUSE_EN
    test_pause();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
